// File: rtl/bus_timer.sv
// Memory-mapped timer peripheral on the MEM-stage data bus: reloadable TH/TL
// up-counter with prescaler, sticky overflow status driving IRQ, and SYSTICK.
module bus_timer #(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
    parameter int unsigned PRESCALE  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Address,
    input  logic [31:0] Write_data,
    input  logic        MemRead,
    input  logic        MemWrite,
    output logic [31:0] Read_data,
    output logic        IRQ
);

    localparam logic [15:0] PRE_LAST = 16'(PRESCALE - 1);

    logic [31:0] th_q, th_d;
    logic [31:0] tl_q, tl_d;
    logic [2:0]  tcon_q, tcon_d;
    logic [31:0] systick_q, systick_d;
    logic [15:0] pre_q, pre_d;
    logic        irq_q, irq_d;

    logic sel_th_s, sel_tl_s, sel_tcon_s, sel_sys_s;
    logic we_th_s, we_tl_s, we_tcon_s, we_sys_s;
    logic tick_s, ovf_s;

    assign sel_th_s   = (Address == BASE_ADDR);
    assign sel_tl_s   = (Address == (BASE_ADDR + 32'h0000_0004));
    assign sel_tcon_s = (Address == (BASE_ADDR + 32'h0000_0008));
    assign sel_sys_s  = (Address == (BASE_ADDR + 32'h0000_0014));

    assign we_th_s    = MemWrite & sel_th_s;
    assign we_tl_s    = MemWrite & sel_tl_s;
    assign we_tcon_s  = MemWrite & sel_tcon_s;
    assign we_sys_s   = MemWrite & sel_sys_s;

    assign tick_s = tcon_q[0] & (pre_q == PRE_LAST);
    assign ovf_s  = tick_s & (tl_q == 32'hFFFF_FFFF);

    // Combinational load data; always shows the pre-write register contents.
    always_comb begin
        Read_data = 32'h0000_0000;
        if (MemRead) begin
            if (sel_th_s) begin
                Read_data = th_q;
            end else if (sel_tl_s) begin
                Read_data = tl_q;
            end else if (sel_tcon_s) begin
                Read_data = {29'h0000_0000, tcon_q};
            end else if (sel_sys_s) begin
                Read_data = systick_q;
            end else begin
                Read_data = 32'h0000_0000;
            end
        end else begin
            Read_data = 32'h0000_0000;
        end
    end

    // Next-state logic: bus writes take priority over counting on TL, while
    // an overflow may still set status alongside a TCON write (set wins).
    always_comb begin
        pre_d = 16'd0;
        if (!tcon_q[0]) begin
            pre_d = 16'd0;
        end else if (tick_s) begin
            pre_d = 16'd0;
        end else begin
            pre_d = pre_q + 16'd1;
        end

        th_d = we_th_s ? Write_data : th_q;

        tl_d = tl_q;
        if (we_tl_s) begin
            tl_d = Write_data;
        end else if (ovf_s) begin
            tl_d = th_q;
        end else if (tick_s) begin
            tl_d = tl_q + 32'd1;
        end else begin
            tl_d = tl_q;
        end

        tcon_d = tcon_q;
        if (we_tcon_s) begin
            tcon_d = {Write_data[2] | (ovf_s & Write_data[1]), Write_data[1:0]};
        end else if (ovf_s & tcon_q[1]) begin
            tcon_d = {1'b1, tcon_q[1:0]};
        end else begin
            tcon_d = tcon_q;
        end

        systick_d = we_sys_s ? Write_data : (systick_q + 32'd1);
        irq_d     = tcon_d[1] & tcon_d[2];
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            th_q      <= 32'h0000_0000;
            tl_q      <= 32'h0000_0000;
            tcon_q    <= 3'b000;
            systick_q <= 32'h0000_0000;
            pre_q     <= 16'd0;
            irq_q     <= 1'b0;
        end else begin
            th_q      <= th_d;
            tl_q      <= tl_d;
            tcon_q    <= tcon_d;
            systick_q <= systick_d;
            pre_q     <= pre_d;
            irq_q     <= irq_d;
        end
    end

    assign IRQ = irq_q;

endmodule

// File: tb/tb_bus_timer.sv
// Scoreboard bench for bus_timer: two instances (PRESCALE=1 and 4) share the bus;
// reads push expectations, a negedge monitor pops and compares.
module tb_bus_timer;

    localparam logic [31:0] B  = 32'h4000_0000;
    localparam logic [31:0] TH = B;
    localparam logic [31:0] TL = B + 32'h4;
    localparam logic [31:0] TC = B + 32'h8;
    localparam logic [31:0] ST = B + 32'h14;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Address;
    logic [31:0] Write_data;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] rd1, rd4;
    logic        irq1, irq4;

    bus_timer #(.BASE_ADDR(B), .PRESCALE(1)) dut1 (
        .clk(clk), .reset(reset), .Address(Address), .Write_data(Write_data),
        .MemRead(MemRead), .MemWrite(MemWrite), .Read_data(rd1), .IRQ(irq1)
    );

    bus_timer #(.BASE_ADDR(B), .PRESCALE(4)) dut4 (
        .clk(clk), .reset(reset), .Address(Address), .Write_data(Write_data),
        .MemRead(MemRead), .MemWrite(MemWrite), .Read_data(rd4), .IRQ(irq4)
    );

    always #5 clk = ~clk;

    string       name_q[$];
    logic [31:0] data_q[$];
    logic        irq_q[$];
    bit          sel_q[$];

    int  tests = 0;
    int  fails = 0;
    bit  cur4  = 1'b0;
    bit  check_end = 1'b0;

    string       m_name;
    logic [31:0] m_data, m_act;
    logic        m_irq, m_acti;
    bit          m_sel;

    // Monitor: whenever a load is presented, compare against the oldest expectation.
    always @(negedge clk) begin
        if (MemRead) begin
            if (data_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_read addr=%h got=%h expected=no read", Address, rd1);
            end else begin
                m_name = name_q.pop_front();
                m_data = data_q.pop_front();
                m_irq  = irq_q.pop_front();
                m_sel  = sel_q.pop_front();
                m_act  = m_sel ? rd4 : rd1;
                m_acti = m_sel ? irq4 : irq1;
                tests++;
                if (m_act !== m_data) begin
                    fails++;
                    $display("FAIL %s data: got %h expected %h", m_name, m_act, m_data);
                end
                tests++;
                if (m_acti !== m_irq) begin
                    fails++;
                    $display("FAIL %s irq: got %b expected %b", m_name, m_acti, m_irq);
                end
            end
        end
        if (check_end) begin
            tests++;
            if (data_q.size() != 0) begin
                fails++;
                $display("FAIL scoreboard_drain: got %0d pending expected 0", data_q.size());
            end
            check_end = 1'b0;
        end
    end

    task automatic push(input string nm, input logic [31:0] d, input logic i);
        name_q.push_back(nm);
        data_q.push_back(d);
        irq_q.push_back(i);
        sel_q.push_back(cur4);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            MemRead  = 1'b0;
            MemWrite = 1'b0;
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        @(posedge clk);
        #1;
        Address    = a;
        Write_data = d;
        MemWrite   = 1'b1;
        MemRead    = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] d, input logic i, input string nm);
        @(posedge clk);
        #1;
        Address  = a;
        MemRead  = 1'b1;
        MemWrite = 1'b0;
        push(nm, d, i);
    endtask

    task automatic rw(input logic [31:0] a, input logic [31:0] wd, input logic [31:0] d,
                      input logic i, input string nm);
        @(posedge clk);
        #1;
        Address    = a;
        Write_data = wd;
        MemRead    = 1'b1;
        MemWrite   = 1'b1;
        push(nm, d, i);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        reset    = 1'b1;
        #2;
        reset    = 1'b0;
    endtask

    task automatic reset_read(input logic [31:0] a, input string nm);
        @(posedge clk);
        #2;
        reset    = 1'b1;
        Address  = a;
        MemRead  = 1'b1;
        MemWrite = 1'b0;
        push(nm, 32'h0, 1'b0);
        @(negedge clk);
        #1;
        reset    = 1'b0;
        MemRead  = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        Address    = 32'h0;
        Write_data = 32'h0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state; SYSTICK counts the five edges since release.
        cur4 = 1'b0;
        idle(4);
        rd(ST, 32'd5, 1'b0, "rst_systick");
        rd(TH, 32'h0, 1'b0, "rst_th");
        rd(TL, 32'h0, 1'b0, "rst_tl");
        rd(TC, 32'h0, 1'b0, "rst_tcon");

        // PRESCALE=1 overflow, reload and IRQ.
        do_reset();
        wr(TH, 32'hFFFF_FFF0);
        wr(TL, 32'hFFFF_FFFE);
        wr(TC, 32'h3);
        rd(TL, 32'hFFFF_FFFE, 1'b0, "p1_tl0");
        rd(TL, 32'hFFFF_FFFF, 1'b0, "p1_tl1");
        rd(TL, 32'hFFFF_FFF0, 1'b1, "p1_reload");
        rd(TC, 32'h7, 1'b1, "p1_status");
        wr(TC, 32'h3);
        rd(TC, 32'h3, 1'b0, "p1_clear");
        wr(TL, 32'd100);
        rd(TL, 32'd100, 1'b0, "p1_tl_write_wins");
        rd(TL, 32'd101, 1'b0, "p1_tl_count");

        // PRESCALE=4 counting, disable hold, re-enable resume.
        cur4 = 1'b1;
        do_reset();
        wr(TC, 32'h1);
        idle(12);
        rd(TL, 32'd3, 1'b0, "p4_tl12");
        wr(TC, 32'h0);
        idle(10);
        rd(TL, 32'd3, 1'b0, "p4_hold");
        rd(TC, 32'h0, 1'b0, "p4_tcon_off");
        wr(TC, 32'h1);
        idle(3);
        rd(TL, 32'd3, 1'b0, "p4_resume3");
        rd(TL, 32'd4, 1'b0, "p4_resume4");

        // Overflow coinciding with bus writes.
        cur4 = 1'b0;
        do_reset();
        wr(TH, 32'd5);
        wr(TL, 32'hFFFF_FFFE);
        wr(TC, 32'h1);
        idle(1);
        wr(TC, 32'h3);
        rd(TC, 32'h7, 1'b1, "ovf_set_wins");
        rd(TL, 32'd6, 1'b1, "ovf_reload_a");

        do_reset();
        wr(TH, 32'd5);
        wr(TL, 32'hFFFF_FFFE);
        wr(TC, 32'h3);
        idle(1);
        wr(TC, 32'h1);
        rd(TC, 32'h1, 1'b0, "ovf_ie_cleared");
        rd(TL, 32'd6, 1'b0, "ovf_reload_b");

        do_reset();
        wr(TH, 32'd5);
        wr(TL, 32'hFFFF_FFFE);
        wr(TC, 32'h1);
        idle(1);
        wr(TH, 32'd9);
        rd(TL, 32'd5, 1'b0, "ovf_old_th");
        rd(TH, 32'd9, 1'b0, "ovf_new_th");

        // Unmapped addresses, read+write together, SYSTICK load.
        do_reset();
        wr(TH, 32'h11);
        wr(TL, 32'h22);
        wr(TC, 32'h2);
        rd(B + 32'hC, 32'h0, 1'b0, "unmap_rd_0c");
        rd(B + 32'h2, 32'h0, 1'b0, "unmap_rd_02");
        rd(32'h0,     32'h0, 1'b0, "unmap_rd_zero");
        wr(B + 32'hC, 32'hFFFF_FFFF);
        wr(B + 32'h2, 32'hFFFF_FFFF);
        wr(32'h0,     32'hFFFF_FFFF);
        rd(TH, 32'h11, 1'b0, "unmap_th");
        rd(TL, 32'h22, 1'b0, "unmap_tl");
        rd(TC, 32'h2,  1'b0, "unmap_tcon");
        rw(TH, 32'h33, 32'h11, 1'b0, "rw_prewrite");
        rd(TH, 32'h33, 1'b0, "rw_written");
        wr(ST, 32'd100);
        rd(ST, 32'd100, 1'b0, "systick_load");

        // Asynchronous reset while running with IRQ asserted.
        do_reset();
        wr(TH, 32'h0);
        wr(TL, 32'hFFFF_FFFF);
        wr(TC, 32'h3);
        rd(TC, 32'h3, 1'b0, "ar_armed");
        rd(TC, 32'h7, 1'b1, "ar_irq");
        reset_read(TC, "ar_during_reset");
        idle(3);
        rd(TL, 32'h0, 1'b0, "ar_tl_stopped");
        rd(TC, 32'h0, 1'b0, "ar_tcon");
        rd(TH, 32'h0, 1'b0, "ar_th");

        idle(1);
        check_end = 1'b1;
        idle(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
